// File: rtl/battle_pkg.sv
// ============================================================
// battle_pkg : battle state codes, menu commands, HP helper
// Rev 1.0
// ============================================================
`default_nettype none

package battle_pkg;

   typedef enum logic [3:0] {
      MENU   = 4'b0000,
      FIGHT  = 4'b0001,
      DAMAGE = 4'b0010,
      DIALOG = 4'b0011,
      DODGE  = 4'b0100,
      WIN    = 4'b0101,
      LOSE   = 4'b0110,
      IDLE   = 4'b1010
   } battle_state_t;

   localparam logic [1:0] CMD_FIGHT = 2'b00;
   localparam logic [1:0] CMD_ACT   = 2'b01;
   localparam logic [1:0] CMD_TALK  = 2'b10;
   localparam logic [1:0] CMD_MERCY = 2'b11;

   // Overkill damage clamps at zero instead of wrapping.
   function automatic logic [10:0] sat_sub(input logic [10:0] hp, input logic [10:0] dmg);
      return (dmg >= hp) ? 11'd0 : (hp - dmg);
   endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================
// frame_timer : counts VGA frame ticks up to a target, done level
// Rev 1.0
// ============================================================
`default_nettype none

module frame_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [7:0]  target_in,
   output logic        done_out
);

   logic [7:0] count_q;
   logic [7:0] count_d;
   logic       frame_tick;

   assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

   // Clear wins over a tick in the same cycle; the count parks at the target.
   always_comb begin
      count_d = count_q;
      if (clear_in) begin
         count_d = 8'd0;
      end else if (frame_tick && (count_q < target_in)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_out = (count_q >= target_in);

endmodule

`default_nettype wire

// File: rtl/battle_phase_scheduler.sv
// ============================================================
// battle_phase_scheduler : battle turn sequencer, owns enemy HP and turns
// Rev 1.0
// ============================================================
`default_nettype none

module battle_phase_scheduler
   import battle_pkg::*;
#(
   parameter logic [10:0] MAX_HP        = 11'd1000,
   parameter logic [10:0] MERCY_HP      = 11'd200,
   parameter logic [7:0]  DAMAGE_FRAMES = 8'd60,
   parameter logic [7:0]  DIALOG_FRAMES = 8'd90
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        start_in,
   input  logic        menu_finished_in,
   input  logic [1:0]  menu_command_in,
   input  logic        fight_finished_in,
   input  logic [10:0] damage_in,
   input  logic        dodge_finished_in,
   input  logic [7:0]  player_hp_in,
   output logic [3:0]  state_out,
   output logic        phase_start_out,
   output logic [10:0] enemy_hp_out,
   output logic [7:0]  turn_count_out
);

   battle_state_t state_q, state_d;
   logic [10:0]   hp_q, hp_d;
   logic [7:0]    turn_q, turn_d;
   logic          phase_start_q, phase_start_d;
   logic [7:0]    frame_target;
   logic          frame_done;

   always_comb begin
      case (state_q)
         DAMAGE:  frame_target = DAMAGE_FRAMES;
         DIALOG:  frame_target = DIALOG_FRAMES;
         default: frame_target = 8'hFF;
      endcase
   end

   // Timer restarts on every state entry so each phase sees a fresh count.
   frame_timer u_frame_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_in  (phase_start_d),
      .hcount_in (hcount_in),
      .vcount_in (vcount_in),
      .target_in (frame_target),
      .done_out  (frame_done)
   );

   always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      turn_d  = turn_q;
      case (state_q)
         IDLE: begin
            if (start_in) state_d = MENU;
         end
         MENU: begin
            if (menu_finished_in) begin
               case (menu_command_in)
                  CMD_FIGHT: state_d = FIGHT;
                  CMD_MERCY: state_d = (hp_q <= MERCY_HP) ? WIN : DIALOG;
                  default:   state_d = DIALOG;
               endcase
            end
         end
         FIGHT: begin
            if (fight_finished_in) begin
               hp_d    = sat_sub(hp_q, damage_in);
               state_d = DAMAGE;
            end
         end
         DAMAGE: begin
            if (frame_done) state_d = (hp_q == 11'd0) ? WIN : DIALOG;
         end
         DIALOG: begin
            if (frame_done) state_d = DODGE;
         end
         DODGE: begin
            // A dead player loses even if the dodge finished that same cycle.
            if (player_hp_in == 8'd0) begin
               state_d = LOSE;
            end else if (dodge_finished_in) begin
               state_d = MENU;
               if (turn_q != 8'hFF) turn_d = turn_q + 8'd1;
            end
         end
         WIN, LOSE: begin
            if (start_in) begin
               state_d = IDLE;
               hp_d    = MAX_HP;
               turn_d  = 8'd0;
            end
         end
         default: state_d = IDLE;
      endcase
      phase_start_d = (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         hp_q          <= MAX_HP;
         turn_q        <= 8'd0;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hp_q          <= hp_d;
         turn_q        <= turn_d;
         phase_start_q <= phase_start_d;
      end
   end

   assign state_out       = state_q;
   assign phase_start_out = phase_start_q;
   assign enemy_hp_out    = hp_q;
   assign turn_count_out  = turn_q;

endmodule

`default_nettype wire

// File: tb/tb_battle_phase_scheduler.sv
// ============================================================
// tb_battle_phase_scheduler : directed scoreboard bench for the battle sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module tb_battle_phase_scheduler;
   import battle_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] hcount_in = 11'd1;
   logic [9:0]  vcount_in = 10'd0;
   logic        start_in = 1'b0;
   logic        menu_finished_in = 1'b0;
   logic [1:0]  menu_command_in = 2'b00;
   logic        fight_finished_in = 1'b0;
   logic [10:0] damage_in = 11'd0;
   logic        dodge_finished_in = 1'b0;
   logic [7:0]  player_hp_in = 8'd50;
   logic [3:0]  state_out;
   logic        phase_start_out;
   logic [10:0] enemy_hp_out;
   logic [7:0]  turn_count_out;

   battle_phase_scheduler dut (
      .clk               (clk),
      .rst               (rst),
      .hcount_in         (hcount_in),
      .vcount_in         (vcount_in),
      .start_in          (start_in),
      .menu_finished_in  (menu_finished_in),
      .menu_command_in   (menu_command_in),
      .fight_finished_in (fight_finished_in),
      .damage_in         (damage_in),
      .dodge_finished_in (dodge_finished_in),
      .player_hp_in      (player_hp_in),
      .state_out         (state_out),
      .phase_start_out   (phase_start_out),
      .enemy_hp_out      (enemy_hp_out),
      .turn_count_out    (turn_count_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic        ps;
      logic [10:0] hp;
      logic [7:0]  turn;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [10:0] model_hp = 11'd1000;
   logic [7:0]  model_turn = 8'd0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input battle_state_t st, input logic ps);
      exp_t e;
      e.tag  = tag;
      e.st   = st;
      e.ps   = ps;
      e.hp   = model_hp;
      e.turn = model_turn;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      cmp({e.tag, ".state"}, 32'(state_out), 32'(e.st));
      cmp({e.tag, ".phase_start"}, 32'(phase_start_out), 32'(e.ps));
      cmp({e.tag, ".enemy_hp"}, 32'(enemy_hp_out), 32'(e.hp));
      cmp({e.tag, ".turns"}, 32'(turn_count_out), 32'(e.turn));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expectation is queued with the stimulus, then checked after the edge.
   task automatic act(input string tag, input battle_state_t st, input logic ps);
      push_exp(tag, st, ps);
      step();
      start_in          = 1'b0;
      menu_finished_in  = 1'b0;
      fight_finished_in = 1'b0;
      dodge_finished_in = 1'b0;
      hcount_in         = 11'd1;
      vcount_in         = 10'd0;
      pop_check();
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         hcount_in = 11'd0;
         vcount_in = 10'd0;
         step();
         hcount_in = 11'd1;
         step();
      end
   endtask

   task automatic timed(input string tag, input battle_state_t now_st,
                        input battle_state_t next_st, input int n);
      tick_n(n - 1);
      hcount_in = 11'd0;
      vcount_in = 10'd0;
      act({tag, "_hold"}, now_st, 1'b0);
      act({tag, "_done"}, next_st, 1'b1);
   endtask

   task automatic menu_cmd(input string tag, input logic [1:0] cmd, input battle_state_t st);
      menu_finished_in = 1'b1;
      menu_command_in  = cmd;
      act(tag, st, 1'b1);
   endtask

   task automatic fight(input string tag, input logic [10:0] dmg);
      fight_finished_in = 1'b1;
      damage_in         = dmg;
      model_hp          = (dmg >= model_hp) ? 11'd0 : model_hp - dmg;
      act(tag, DAMAGE, 1'b1);
   endtask

   task automatic dodge_ok(input string tag);
      dodge_finished_in = 1'b1;
      model_turn        = model_turn + 8'd1;
      act(tag, MENU, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) step();
      push_exp("reset", IDLE, 1'b0);
      pop_check();
      rst = 1'b1;
      step();

      start_in = 1'b1;
      act("start", MENU, 1'b1);
      act("menu_hold", MENU, 1'b0);
      fight_finished_in = 1'b1;
      damage_in         = 11'd500;
      act("stray_fight", MENU, 1'b0);
      menu_cmd("cmd_fight", CMD_FIGHT, FIGHT);
      fight("dmg300", 11'd300);
      timed("damage60", DAMAGE, DIALOG, 60);
      timed("dialog90", DIALOG, DODGE, 90);
      dodge_ok("dodge1");

      menu_cmd("mercy700", CMD_MERCY, DIALOG);
      timed("dialog_b", DIALOG, DODGE, 90);
      dodge_ok("dodge2");

      menu_cmd("cmd_fight_c", CMD_FIGHT, FIGHT);
      fight("dmg499", 11'd499);
      timed("damage_c", DAMAGE, DIALOG, 60);
      timed("dialog_c", DIALOG, DODGE, 90);
      dodge_ok("dodge3");
      menu_cmd("mercy201", CMD_MERCY, DIALOG);
      timed("dialog_d", DIALOG, DODGE, 90);

      #3;
      rst = 1'b0;
      #1;
      model_hp   = 11'd1000;
      model_turn = 8'd0;
      push_exp("async_rst", IDLE, 1'b0);
      pop_check();
      step();
      rst = 1'b1;
      step();

      start_in = 1'b1;
      act("start_e", MENU, 1'b1);
      menu_cmd("cmd_fight_e", CMD_FIGHT, FIGHT);
      fight("dmg800", 11'd800);
      timed("damage_e", DAMAGE, DIALOG, 60);
      timed("dialog_e", DIALOG, DODGE, 90);
      dodge_ok("dodge_e");
      menu_cmd("mercy200", CMD_MERCY, WIN);
      start_in   = 1'b1;
      model_hp   = 11'd1000;
      model_turn = 8'd0;
      act("restart_win", IDLE, 1'b1);

      start_in = 1'b1;
      act("start_f", MENU, 1'b1);
      menu_cmd("cmd_fight_f", CMD_FIGHT, FIGHT);
      fight("dmg850", 11'd850);
      timed("damage_f", DAMAGE, DIALOG, 60);
      timed("dialog_f", DIALOG, DODGE, 90);
      dodge_ok("dodge_f");
      menu_cmd("cmd_fight_f2", CMD_FIGHT, FIGHT);
      fight("overkill400", 11'd400);
      timed("damage_kill", DAMAGE, WIN, 60);
      start_in   = 1'b1;
      model_hp   = 11'd1000;
      model_turn = 8'd0;
      act("restart_kill", IDLE, 1'b1);

      start_in = 1'b1;
      act("start_g", MENU, 1'b1);
      menu_cmd("cmd_act", CMD_ACT, DIALOG);
      timed("dialog_g", DIALOG, DODGE, 90);
      dodge_ok("dodge_g");
      menu_cmd("cmd_talk", CMD_TALK, DIALOG);
      timed("dialog_g2", DIALOG, DODGE, 90);
      player_hp_in      = 8'd0;
      dodge_finished_in = 1'b1;
      act("lose_priority", LOSE, 1'b1);
      player_hp_in = 8'd50;
      act("lose_hold", LOSE, 1'b0);
      start_in   = 1'b1;
      model_hp   = 11'd1000;
      model_turn = 8'd0;
      act("restart_lose", IDLE, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
